rb_uart_port: RTL

RB_UART_PORT -- requirements
Module: rb_uart_port

---
 rtl/rb_periph_pkg.sv | 40 ++++
 rtl/rb_fifo4.sv | 52 +++++
 rtl/rb_uart_port.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rb_periph_pkg.sv
// Shared definitions for right-bank peripherals: register offsets, status bit
// positions, serial-engine state encoding and the status-byte packer.
// No logic or ports; imported by rb_fifo4 users and rb_uart_port.
package rb_periph_pkg;

    // Register offsets relative to a peripheral's BASE_ADDR.
    localparam logic [7:0] REG_DATA = 8'd0;
    localparam logic [7:0] REG_STAT = 8'd1;

    // Status register bit positions.
    localparam int unsigned STAT_RX_NOT_EMPTY = 0;
    localparam int unsigned STAT_TX_NOT_FULL  = 1;
    localparam int unsigned STAT_TX_BUSY      = 2;
    localparam int unsigned STAT_RX_OVERRUN   = 3;
    localparam int unsigned STAT_FRAME_ERR    = 4;

    // Common state encoding for the TX and RX serial engines.
    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_START = 2'd1,
        ENG_DATA  = 2'd2,
        ENG_STOP  = 2'd3
    } eng_state_t;

    function automatic logic [7:0] pack_status(input logic frame_err,
                                               input logic rx_overrun,
                                               input logic tx_busy,
                                               input logic tx_not_full,
                                               input logic rx_not_empty);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_FRAME_ERR]    = frame_err;
        s[STAT_RX_OVERRUN]   = rx_overrun;
        s[STAT_TX_BUSY]      = tx_busy;
        s[STAT_TX_NOT_FULL]  = tx_not_full;
        s[STAT_RX_NOT_EMPTY] = rx_not_empty;
        return s;
    endfunction

endpackage

// File: rtl/rb_fifo4.sv
// 4x8 synchronous FIFO, head is combinational from the read pointer.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, head, full, empty.
module rb_fifo4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count == 3'd0);
    assign full    = (count == 3'd4);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rb_uart_port.sv
// Right-bank UART: data register feeds a 4-deep TX FIFO, RX bytes land in a 4-deep RX FIFO.
// Latency: TX frame starts 2 clks after the data write; RX byte is readable the clk after its stop sample.
// Backpressure: none on the bus; full TX FIFO drops writes, full RX FIFO drops bytes and sets rx_overrun.
// Ports: clk, rst (sync, active-high), RB_A/RB_Dout/RB_wr/RB_rd/RB_Din register bus, rx/tx serial lines.
module rb_uart_port
    import rb_periph_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hF0,
    parameter logic [15:0] CLK_DIV   = 16'd434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] RB_A,
    input  logic [7:0] RB_Dout,
    input  logic       RB_wr,
    input  logic       RB_rd,
    output logic [7:0] RB_Din,
    input  logic       rx,
    output logic       tx
);

    localparam logic [7:0]  DATA_ADDR = BASE_ADDR + REG_DATA;
    localparam logic [7:0]  STAT_ADDR = BASE_ADDR + REG_STAT;
    localparam logic [15:0] DIV_M1    = CLK_DIV - 16'd1;
    // RX re-checks the start bit half a bit time after the falling edge.
    localparam logic [15:0] HALF_M1   = (CLK_DIV >> 1) - 16'd1;

    logic       sel_data, sel_stat, stat_wr;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_end;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_end, rx_stop_done;
    logic [7:0] rx_head;

    eng_state_t tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_overrun, frame_err;

    assign sel_data = (RB_A == DATA_ADDR);
    assign sel_stat = (RB_A == STAT_ADDR);
    assign stat_wr  = RB_wr && sel_stat;

    assign tx_push = RB_wr && sel_data;
    assign tx_end  = (tx_cnt == DIV_M1);
    // The engine takes a byte when idle, or straight out of a stop bit for gapless frames.
    assign tx_pop  = !tx_empty && ((tx_state == ENG_IDLE) || (tx_state == ENG_STOP && tx_end));
    assign tx_busy = (tx_state != ENG_IDLE) || !tx_empty;

    assign rx_pop       = RB_rd && sel_data;
    assign rx_end       = (rx_cnt == DIV_M1);
    assign rx_stop_done = (rx_state == ENG_STOP) && rx_end;
    assign rx_push      = rx_stop_done && rx_s2;

    rb_fifo4 u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_dat(RB_Dout), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    rb_fifo4 u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_dat(rx_sh), .pop(rx_pop),
        .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // TX engine; tx is registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ENG_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_sh    <= 8'h00;
            tx       <= 1'b1;
        end else begin
            tx_cnt <= tx_end ? 16'd0 : tx_cnt + 16'd1;
            case (tx_state)
                ENG_IDLE: begin
                    tx_cnt <= 16'd0;
                    if (tx_pop) begin
                        tx_sh    <= tx_head;
                        tx       <= 1'b0;
                        tx_state <= ENG_START;
                    end
                end
                ENG_START: if (tx_end) begin
                    tx       <= tx_sh[0];
                    tx_sh    <= {1'b0, tx_sh[7:1]};
                    tx_bit   <= 3'd0;
                    tx_state <= ENG_DATA;
                end
                ENG_DATA: if (tx_end) begin
                    if (tx_bit == 3'd7) begin
                        tx       <= 1'b1;
                        tx_state <= ENG_STOP;
                    end else begin
                        tx     <= tx_sh[0];
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_bit <= tx_bit + 3'd1;
                    end
                end
                ENG_STOP: if (tx_end) begin
                    if (tx_pop) begin
                        tx_sh    <= tx_head;
                        tx       <= 1'b0;
                        tx_state <= ENG_START;
                    end else begin
                        tx_state <= ENG_IDLE;
                    end
                end
                default: tx_state <= ENG_IDLE;
            endcase
        end
    end

    // RX synchroniser plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= ENG_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
            case (rx_state)
                ENG_IDLE: begin
                    rx_cnt <= 16'd0;
                    if (rx_prev && !rx_s2) rx_state <= ENG_START;
                end
                ENG_START: if (rx_cnt == HALF_M1) begin
                    rx_cnt   <= 16'd0;
                    rx_bit   <= 3'd0;
                    rx_state <= rx_s2 ? ENG_IDLE : ENG_DATA;
                end
                ENG_DATA: if (rx_end) begin
                    rx_cnt <= 16'd0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= ENG_STOP;
                end
                ENG_STOP: if (rx_end) begin
                    rx_cnt   <= 16'd0;
                    rx_state <= ENG_IDLE;
                end
                default: rx_state <= ENG_IDLE;
            endcase
        end
    end

    // Sticky flags; the set terms come last so they win over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (stat_wr && RB_Dout[3]) rx_overrun <= 1'b0;
            if (stat_wr && RB_Dout[4]) frame_err  <= 1'b0;
            if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
            if (rx_stop_done && !rx_s2) frame_err <= 1'b1;
        end
    end

    // Read mux; reset forces the reset-state view even before the first edge.
    always_comb begin
        RB_Din = 8'h00;
        if (sel_data && !rst && !rx_empty) begin
            RB_Din = rx_head;
        end else if (sel_stat) begin
            RB_Din = rst ? pack_status(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)
                         : pack_status(frame_err, rx_overrun, tx_busy, !tx_full, !rx_empty);
        end
    end

endmodule
